// File: rtl/spi_reg_bridge_if.sv
// FIFO-side bundle between the SPI slave's RX/TX FIFO pair and the register bridge.
// The bridge is the master because it issues pops and pushes. The FIFO side is the slave.
interface spi_reg_bridge_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] rx_data;
   logic             rx_empty;
   logic             rx_read_en;
   logic             tx_full;
   logic [WIDTH-1:0] tx_data;
   logic             tx_write_en;

   modport master (
      input  rx_data, rx_empty, tx_full,
      output rx_read_en, tx_data, tx_write_en
   );

   modport slave (
      output rx_data, rx_empty, tx_full,
      input  rx_read_en, tx_data, tx_write_en
   );
endinterface

// File: rtl/spi_reg_bridge.sv
// Parses cmd/addr/data bytes from the SPI RX FIFO into a register file. It takes at least 4 clk per byte.
// Read data goes to the TX FIFO. A PUSH waits while tx_full, and the RX FIFO is not popped during PUSH.
module spi_reg_bridge #(
   parameter int               WIDTH         = 8,
   parameter int               ADDR_WIDTH    = 7,
   parameter int               NUM_REGS      = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
   parameter logic [WIDTH-1:0] UNMAPPED_READ = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cs_n,
   spi_reg_bridge_if.master          fifo,
   output logic [NUM_REGS*WIDTH-1:0] reg_q,
   output logic                      reg_we,
   output logic [ADDR_WIDTH-1:0]     reg_waddr,
   output logic [WIDTH-1:0]          reg_wdata,
   output logic                      busy
);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH:0] NUM_REGS_CMP = (ADDR_WIDTH + 1)'(NUM_REGS);

   typedef enum logic [2:0] {S_IDLE, S_POP, S_CAPTURE, S_EXEC, S_PUSH} state_t;
   typedef enum logic [1:0] {PH_CMD, PH_WDATA, PH_RCOUNT, PH_RDISCARD} phase_t;

   state_t              r_state, w_next;
   phase_t              r_phase;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WIDTH-1:0]    r_cnt;
   logic [WIDTH-1:0]    r_byte;
   logic                r_end_pending;
   logic [1:0]          r_cs_sync;
   logic                r_cs_prev;
   logic [WIDTH-1:0]    r_regs [NUM_REGS];

   logic                w_mapped;
   logic [IDX_W-1:0]    w_idx;
   logic                w_push;
   logic                w_wr;
   logic                w_cs_rise;
   logic                w_frame_close;

   assign w_mapped      = ({1'b0, r_addr} < NUM_REGS_CMP);
   assign w_idx         = r_addr[IDX_W-1:0];
   assign w_push        = (r_state == S_PUSH) && !fifo.tx_full;
   assign w_wr          = (r_state == S_EXEC) && (r_phase == PH_WDATA) && w_mapped;
   assign w_cs_rise     = r_cs_sync[1] && !r_cs_prev;
   assign w_frame_close = (r_state == S_IDLE) && fifo.rx_empty && r_end_pending;
   assign fifo.tx_data  = w_mapped ? r_regs[w_idx] : UNMAPPED_READ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next           = r_state;
      fifo.rx_read_en  = 1'b0;
      fifo.tx_write_en = 1'b0;
      busy             = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:    if (!fifo.rx_empty) w_next = S_POP;
         S_POP: begin
            fifo.rx_read_en = 1'b1;
            w_next          = S_CAPTURE;
         end
         S_CAPTURE: w_next = S_EXEC;
         S_EXEC:    w_next = (r_phase == PH_RCOUNT && r_byte != '0) ? S_PUSH : S_IDLE;
         S_PUSH: begin
            fifo.tx_write_en = w_push;
            if (w_push && r_cnt == WIDTH'(1)) w_next = S_IDLE;
         end
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase       <= PH_CMD;
         r_addr        <= '0;
         r_cnt         <= '0;
         r_byte        <= '0;
         r_end_pending <= 1'b0;
         r_cs_sync     <= 2'b11;
         r_cs_prev     <= 1'b1;
         reg_we        <= 1'b0;
         reg_waddr     <= '0;
         reg_wdata     <= '0;
      end else begin
         reg_we    <= 1'b0;
         r_cs_sync <= {r_cs_sync[0], cs_n};
         r_cs_prev <= r_cs_sync[1];
         // A frame closes only once its queued bytes have drained and the machine is idle.
         if (w_cs_rise)          r_end_pending <= 1'b1;
         else if (w_frame_close) r_end_pending <= 1'b0;
         if (w_frame_close)      r_phase       <= PH_CMD;

         case (r_state)
            S_CAPTURE: r_byte <= fifo.rx_data;
            S_EXEC: begin
               case (r_phase)
                  PH_CMD: begin
                     r_addr  <= r_byte[ADDR_WIDTH-1:0];
                     r_phase <= r_byte[WIDTH-1] ? PH_RCOUNT : PH_WDATA;
                  end
                  PH_WDATA: begin
                     if (w_mapped) begin
                        reg_we    <= 1'b1;
                        reg_waddr <= r_addr;
                        reg_wdata <= r_byte;
                     end
                     r_addr <= r_addr + 1'b1;
                  end
                  PH_RCOUNT: begin
                     r_cnt   <= r_byte;
                     r_phase <= PH_RDISCARD;
                  end
                  default: ;
               endcase
            end
            S_PUSH: begin
               if (w_push) begin
                  r_addr <= r_addr + 1'b1;
                  r_cnt  <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
      end else if (w_wr) begin
         r_regs[w_idx] <= r_byte;
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign reg_q[gi*WIDTH +: WIDTH] = r_regs[gi];
   end
endmodule
